pulse_coincidence_core: RTL
===========================

# pulse_coincidence_core

Parametrised coincidence engine for the intensity correlator front end. It conditions NUM_INPUTS raw photon-pulse lines into single-cycle edge pulses of selectable polarity, applies a programmable per-channel lag, and counts pairwise coincidences over a fixed integration window. At each window end it snapshots every pair count and streams the snapshot out through a valid/ready handshake to the UART/report logic. It is the multi-lag, back-pressure-aware successor to the fixed one-cycle edge stage feeding the correlator main block.

## Interface
- NUM_INPUTS, 12, number of pulse channels (≥2)
- RESOLUTION, 16, width of each coincidence counter
- MAX_DELAY, 4, maximum per-channel lag in cycles (≥1)
- INTEGRATION_CYCLES, 400000, window length in enabled cycles (≥2)
- ACTIVE_LOW, 1, 1: count falling edges of pulse_in; 0: count rising edges
- NUM_CORRELATORS, NUM_INPUTS*(NUM_INPUTS-1)/2, derived
- DELAY_BITS, clog2(MAX_DELAY+1), derived; IDX_BITS, clog2(NUM_CORRELATORS), derived (min 1)

- clk  in  1  single clock (PLL output)
- rst  in  1  reset; synchronous, active-high
- pulse_in  in  NUM_INPUTS  raw, already-synchronised pulse lines
- delay_sel  in  NUM_INPUTS*DELAY_BITS  lag of channel i at bits [i*DELAY_BITS +: DELAY_BITS]
- enable  in  1  gates window and coincidence counters
- pulse_out  out  NUM_INPUTS  registered one-cycle edge pulses
- integration_clk_pulse  out  1  one-cycle strobe per completed window
- out_valid  out  1  snapshot beat valid
- out_ready  in  1  consumer accepts beat
- out_index  out  IDX_BITS  pair index of current beat
- out_count  out  RESOLUTION  coincidence count of current beat
- out_last  out  1  current beat is pair NUM_CORRELATORS-1
- overrun  out  1  sticky: a snapshot was dropped

## Operation
- Edge stage: prev register holds last pulse_in; edge = ACTIVE_LOW ? prev&~pulse_in : ~prev&pulse_in; pulse_out <= edge. Reset loads prev with the inactive level (all 1s if ACTIVE_LOW), so no spurious edge after reset.
- Delay stage: per-channel shift register of pulse_out, depth MAX_DELAY. d[i] = pulse_out[i] if sel=0, else tap sel-1 (lag of sel cycles). sel > MAX_DELAY clamps to MAX_DELAY. Delay lines run regardless of enable.
- Pair order: k enumerates (i,j), i<j, lexicographic: (0,1)=0, (0,2)=1, …, (N-2,N-1)=NUM_CORRELATORS-1.
- Counters: when enable and d[i]&d[j], cnt[k] increments; saturates at 2^RESOLUTION-1, never wraps.
- Window: wcnt counts enabled cycles 0..INTEGRATION_CYCLES-1. On an enabled cycle with wcnt=INTEGRATION_CYCLES-1 ("window end"): shadow[k] <= cnt[k] plus that cycle's hit (saturated); cnt[k] <= 0; wcnt <= 0; integration_clk_pulse <= 1.
- enable low: wcnt and cnt hold; stream FSM unaffected.
- Stream FSM, states IDLE/STREAM:
  - IDLE + window end → STREAM, idx=0.
  - STREAM: out_valid=1, out_index=idx, out_count=shadow[idx]; accept (valid&ready) → idx+1; accept with idx=NUM_CORRELATORS-1 → IDLE.
  - Window end in STREAM without final accept that cycle: snapshot dropped (shadow unchanged), cnt still cleared, overrun <= 1.
  - Window end coinciding with final accept: new snapshot taken, remain STREAM, idx=0.
- Reset: all counters, shadow, idx, delay lines 0; FSM IDLE; every output 0; overrun 0.

## Timing
- pulse_in edge at clock n → pulse_out high for exactly cycle n+1.
- Channel with lag L: d[i] high at cycle n+1+L.
- Coincidence in cycle m → cnt visible at m+1.
- Window end at cycle m → integration_clk_pulse and out_valid high at m+1; out_index 0.
- out_index/out_count/out_last stable while out_valid & ~out_ready.
- Full dump with out_ready tied high: NUM_CORRELATORS cycles, one beat per cycle.
- rst mid-stream: out_valid 0 the cycle after rst sampled high.

## Test plan
Configuration: NUM_INPUTS=3, RESOLUTION=3, MAX_DELAY=2, INTEGRATION_CYCLES=16, ACTIVE_LOW=1, enable=1, out_ready=1 unless stated.
- Reset, pulse_in held 3'b111 for 16 cycles → pulse_out never high; beats (idx,count,last) = (0,0,0),(1,0,0),(2,0,1); integration_clk_pulse high 1 cycle.
- Ch0 and ch1 fall in the same cycle, delay_sel 0 → pulse_out=3'b011 one cycle later; snapshot counts 1,0,0.
- Ch1 falls at t, ch0 at t+2, lag(ch1)=2 → pair0 count 1; lag(ch1)=0 → 0; lag(ch1)=3 (clamped to 2) → 1.
- Ch0, ch1 toggle together every cycle (8 falling edges per window) → pair0 count saturates at 7, others 0.
- out_ready=0 across two window ends → overrun=1, outputs hold (0,first snapshot count); release ready → first snapshot's 3 beats, then IDLE.
- rst asserted during beat idx=1 → next cycle out_valid=0, overrun=0, pulse_out=0; following window reports all zeros.

Source files
------------

// File: rtl/pulse_coincidence_core.sv
// pulse_coincidence_core
// Edge-conditions the raw photon lines, applies a per-channel lag, counts
// pairwise coincidences over a fixed window and streams each window's
// pair counts out through a valid/ready handshake.
module pulse_coincidence_core #(
  parameter int NUM_INPUTS         = 12,
  parameter int RESOLUTION         = 16,
  parameter int MAX_DELAY          = 4,
  parameter int INTEGRATION_CYCLES = 400000,
  parameter int ACTIVE_LOW         = 1,
  localparam int NUM_CORRELATORS   = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
  localparam int DELAY_BITS        = $clog2(MAX_DELAY + 1),
  localparam int IDX_BITS          = (NUM_CORRELATORS > 1) ? $clog2(NUM_CORRELATORS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            pulse_in,
  input  logic [NUM_INPUTS*DELAY_BITS-1:0] delay_sel,
  input  logic                             enable,
  output logic [NUM_INPUTS-1:0]            pulse_out,
  output logic                             integration_clk_pulse,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDX_BITS-1:0]              out_index,
  output logic [RESOLUTION-1:0]            out_count,
  output logic                             out_last,
  output logic                             overrun
);

  localparam int WCNT_W = $clog2(INTEGRATION_CYCLES);
  localparam logic [WCNT_W-1:0]     WCNT_LAST  = WCNT_W'(INTEGRATION_CYCLES - 1);
  localparam logic [IDX_BITS-1:0]   IDX_LAST   = IDX_BITS'(NUM_CORRELATORS - 1);
  localparam logic [NUM_INPUTS-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  // Saturating increment: a full counter stays full instead of wrapping.
  function automatic logic [RESOLUTION-1:0] sat_inc(input logic [RESOLUTION-1:0] v,
                                                     input logic hit);
    return (hit && !(&v)) ? v + RESOLUTION'(1) : v;
  endfunction

  // Lag request clamped to the physical depth of the delay line.
  function automatic int clamp_lag(input logic [DELAY_BITS-1:0] s);
    return (int'(s) > MAX_DELAY) ? MAX_DELAY : int'(s);
  endfunction

  logic [NUM_INPUTS-1:0]      prev_p0;
  logic [NUM_INPUTS-1:0]      edge_p0;
  logic [MAX_DELAY-1:0]       dly_p1 [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]      d_p1;
  logic [NUM_CORRELATORS-1:0] hit_p1;
  logic [RESOLUTION-1:0]      cnt_p2 [NUM_CORRELATORS];
  logic [RESOLUTION-1:0]      shadow [NUM_CORRELATORS];
  logic [WCNT_W-1:0]          wcnt;
  logic [IDX_BITS-1:0]        idx;
  state_t                     state_q, state_d;
  logic                       win_end, accept, final_acc, take_snap;

  // ---- stage p0: edge detection on the raw lines ----
  assign edge_p0 = (ACTIVE_LOW != 0) ? (prev_p0 & ~pulse_in) : (~prev_p0 & pulse_in);

  // Previous-level register and registered one-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_p0   <= IDLE_LEVEL;
      pulse_out <= '0;
    end else begin
      prev_p0   <= pulse_in;
      pulse_out <= edge_p0;
    end
  end

  // ---- stage p1: per-channel lag and pair coincidence ----
  // Delay lines shift every cycle, independent of enable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rst) begin
        dly_p1[i] <= '0;
      end else begin
        dly_p1[i][0] <= pulse_out[i];
        for (int t = 1; t < MAX_DELAY; t++) dly_p1[i][t] <= dly_p1[i][t-1];
      end
    end
  end

  // Tap select: lag 0 is the undelayed pulse, lag L is tap L-1.
  always_comb begin
    d_p1 = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (clamp_lag(delay_sel[i*DELAY_BITS +: DELAY_BITS]) == 0)
        d_p1[i] = pulse_out[i];
      else
        d_p1[i] = dly_p1[i][clamp_lag(delay_sel[i*DELAY_BITS +: DELAY_BITS]) - 1];
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS - 1; gi++) begin : g_row
    for (genvar gj = gi + 1; gj < NUM_INPUTS; gj++) begin : g_col
      localparam int K = gi * NUM_INPUTS - gi * (gi + 1) / 2 + (gj - gi - 1);
      assign hit_p1[K] = d_p1[gi] & d_p1[gj];
    end
  end

  // ---- stage p2: window, counters and snapshot ----
  assign win_end   = enable && (wcnt == WCNT_LAST);
  assign accept    = out_valid && out_ready;
  assign final_acc = accept && (idx == IDX_LAST);
  assign take_snap = win_end && ((state_q == S_IDLE) || final_acc);

  // Window position counts enabled cycles only.
  always_ff @(posedge clk) begin
    if (rst)         wcnt <= '0;
    else if (enable) wcnt <= win_end ? '0 : wcnt + WCNT_W'(1);
  end

  // Coincidence counters clear at window end; the snapshot includes that cycle's hit.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CORRELATORS; k++) begin
      if (rst) begin
        cnt_p2[k] <= '0;
        shadow[k] <= '0;
      end else begin
        if (enable)    cnt_p2[k] <= win_end ? '0 : sat_inc(cnt_p2[k], hit_p1[k]);
        if (take_snap) shadow[k] <= sat_inc(cnt_p2[k], hit_p1[k]);
      end
    end
  end

  // Window strobe and sticky flag for snapshots lost while still streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      integration_clk_pulse <= 1'b0;
      overrun               <= 1'b0;
    end else begin
      integration_clk_pulse <= win_end;
      if (win_end && (state_q == S_STREAM) && !final_acc) overrun <= 1'b1;
    end
  end

  // Stream state and beat index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx     <= '0;
    end else begin
      state_q <= state_d;
      if (take_snap || final_acc) idx <= '0;
      else if (accept)            idx <= idx + IDX_BITS'(1);
    end
  end

  // Next-state: a fresh snapshot starts or restarts the dump.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (win_end) state_d = S_STREAM;
      S_STREAM: if (final_acc && !win_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Beat outputs are driven only while streaming.
  always_comb begin
    out_valid = 1'b0;
    out_index = '0;
    out_count = '0;
    out_last  = 1'b0;
    if (state_q == S_STREAM) begin
      out_valid = 1'b1;
      out_index = idx;
      out_count = shadow[idx];
      out_last  = (idx == IDX_LAST);
    end
  end

endmodule
